// File: rtl/ram_sp_hs.sv
// ram_sp_hs: single-port simulation RAM with valid/ready request and
// response channels, byte-strobe writes, LAT-cycle read pipeline and an
// in-order response FIFO that absorbs backpressure.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake; req_write, req_addr, req_wdata,
//                   req_wstrb carry the request
//   resp_valid/ready response handshake; resp_rdata, resp_is_wr carry it
// Option macro SIM_RAM_WRITE_RESP_EN: writes also return a response and
// consume a credit; otherwise writes commit silently and need no credit.
module ram_sp_hs #(
    parameter int DW        = 128,
    parameter int AW        = 16,
    parameter int LAT       = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wstrb,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_rdata,
    output logic            resp_is_wr
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;
    localparam int CW    = $clog2(BUF_DEPTH + 1);
    localparam int PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW-1:0] CREDITS  = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

`ifdef SIM_RAM_WRITE_RESP_EN
    // Entry carries the is-write flag above the data.
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    if (LAT < 1 || LAT > 4 || BUF_DEPTH < 1 || (DW % 8) != 0) begin : g_bad_cfg
        $error("ram_sp_hs: unsupported LAT/BUF_DEPTH/DW");
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [EW-1:0] fifo_q [BUF_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_q, out_d;

    logic          accept;
    logic          credit_req;
    logic          pop;
    logic          in_v;
    logic [EW-1:0] in_e;
    logic          push_v;
    logic [EW-1:0] push_e;

`ifdef SIM_RAM_WRITE_RESP_EN
    assign credit_req = 1'b1;
    assign in_e = {req_write,
                   req_write ? {DW{1'b0}} : mem_q[req_addr]};
`else
    // Only reads return data, so only reads need a buffer slot.
    assign credit_req = !req_write;
    assign in_e = mem_q[req_addr];
`endif

    assign req_ready = !rst && (!credit_req || (out_q < CREDITS));
    assign accept    = req_valid && req_ready;
    assign in_v      = accept && credit_req;

    // Array is sampled on the accept edge; LAT-1 more stages follow.
    if (LAT == 1) begin : g_direct
        assign push_v = in_v;
        assign push_e = in_e;
    end else begin : g_pipe
        logic          pv_q [LAT-1];
        logic [EW-1:0] pe_q [LAT-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LAT - 1; i++) begin
                    pv_q[i] <= 1'b0;
                    pe_q[i] <= '0;
                end
            end else begin
                pv_q[0] <= in_v;
                pe_q[0] <= in_e;
                for (int i = 1; i < LAT - 1; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pe_q[i] <= pe_q[i-1];
                end
            end
        end

        assign push_v = pv_q[LAT-2];
        assign push_e = pe_q[LAT-2];
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_v) begin
            fifo_q[wr_ptr_q] <= push_e;
        end
    end

    assign resp_valid = (cnt_q != '0);
    assign pop        = resp_valid && resp_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        if (push_v) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_v, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({in_v, pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // Gating by resp_valid keeps outputs at zero in and after reset.
    assign resp_rdata = resp_valid ? fifo_q[rd_ptr_q][DW-1:0] : '0;

`ifdef SIM_RAM_WRITE_RESP_EN
    assign resp_is_wr = resp_valid && fifo_q[rd_ptr_q][DW];
`else
    assign resp_is_wr = 1'b0;
`endif

    // Credits bound pipeline+FIFO occupancy, so a full FIFO never sees a push.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) !(push_v && (cnt_q == CREDITS))
    ) else $error("ram_sp_hs: push into full response FIFO");

endmodule

// File: tb/tb_ram_sp_hs.sv
// tb_ram_sp_hs: directed bench for ram_sp_hs.
// Instance a: LAT=1 BUF_DEPTH=2, instance b: LAT=3 BUF_DEPTH=4.
module tb_ram_sp_hs;

    localparam int DW = 128;
    localparam int AW = 8;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_req_valid, a_req_ready, a_req_write;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata;
    logic [SW-1:0] a_req_wstrb;
    logic          a_resp_valid, a_resp_ready, a_resp_is_wr;
    logic [DW-1:0] a_resp_rdata;

    logic          b_req_valid, b_req_ready, b_req_write;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata;
    logic [SW-1:0] b_req_wstrb;
    logic          b_resp_valid, b_resp_ready, b_resp_is_wr;
    logic [DW-1:0] b_resp_rdata;

    int errors = 0;
    int checks = 0;

    ram_sp_hs #(.DW(DW), .AW(AW), .LAT(1), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_is_wr(a_resp_is_wr)
    );

    ram_sp_hs #(.DW(DW), .AW(AW), .LAT(3), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_is_wr(b_resp_is_wr)
    );

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'h5A00_0000 | 32'(k);
        return {w, ~w, w, 32'h0000_C0DE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input bit sel, input logic w, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        logic rdy;
        if (!sel) begin
            a_req_valid = 1'b1; a_req_write = w; a_req_addr = ad;
            a_req_wdata = d;    a_req_wstrb = s;
        end else begin
            b_req_valid = 1'b1; b_req_write = w; b_req_addr = ad;
            b_req_wdata = d;    b_req_wstrb = s;
        end
        n = 0;
        rdy = sel ? b_req_ready : a_req_ready;
        while (rdy !== 1'b1 && n < 50) begin
            tick();
            n++;
            rdy = sel ? b_req_ready : a_req_ready;
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: req_ready=%b after %0d cycles, required 1",
                     rdy, n);
        end
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic get_read(input bit sel, output logic [DW-1:0] d,
                            output bit found);
        found = 1'b0;
        d = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!sel && a_resp_valid === 1'b1 && a_resp_is_wr === 1'b0) begin
                d = a_resp_rdata;
                found = 1'b1;
            end else if (sel && b_resp_valid === 1'b1 && b_resp_is_wr === 1'b0) begin
                d = b_resp_rdata;
                found = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req_valid = 1'b1;
        a_req_write = 1'b0;
        b_req_valid = 1'b1;
        idle(2);
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_a: got %b, required 0", a_req_ready);
        end
        checks++;
        if (b_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_b: got %b, required 0", b_req_ready);
        end
        checks++;
        if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_valid: got a=%b b=%b, required 0",
                     a_resp_valid, b_resp_valid);
        end
        checks++;
        if (a_resp_rdata !== '0 || a_resp_is_wr !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_data: got %h/%b, required 0/0",
                     a_resp_rdata, a_resp_is_wr);
        end
        rst = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        tick();
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got a=%b b=%b, required 1",
                     a_req_ready, b_req_ready);
        end
        checks++;
        if (a_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_valid: got %b, required 0", a_resp_valid);
        end
    endtask

    task automatic test_strobe();
        logic [DW-1:0] d;
        bit found;
        logic [DW-1:0] ones;
        ones = '1;
        send(0, 1'b1, 8'h10, ones, 16'hFFFF);
        send(0, 1'b1, 8'h10, '0, 16'h00F0);
        send(0, 1'b0, 8'h10, '0, '0);
        get_read(0, d, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL strobe_resp: no read response, required one");
        end
        checks++;
        if (d !== 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF) begin
            errors++;
            $display("FAIL strobe_data: got %h, required %h", d,
                     128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
        end
        idle(3);
    endtask

    task automatic test_latency();
        for (int i = 0; i < 8; i++) begin
            send(1, 1'b1, AW'(i), pat(i), '1);
        end
        idle(8);
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 8'h00;
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_ready: got %b, required 1", b_req_ready);
        end
        tick();
        b_req_valid = 1'b0;
        checks++;
        if (b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle1: resp_valid=%b, required 0", b_resp_valid);
        end
        tick();
        checks++;
        if (b_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle2: resp_valid=%b, required 0", b_resp_valid);
        end
        tick();
        checks++;
        if (b_resp_valid !== 1'b1 || b_resp_rdata !== pat(0)) begin
            errors++;
            $display("FAIL lat_cycle3: valid=%b data=%h, required 1/%h",
                     b_resp_valid, b_resp_rdata, pat(0));
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int tx, rx, gaps, stall;
        bit seen, acc;
        tx = 0; rx = 0; gaps = 0; stall = 0; seen = 1'b0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            if (b_resp_valid === 1'b1) begin
                checks++;
                if (b_resp_rdata !== pat(rx)) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h, required %h",
                             rx, b_resp_rdata, pat(rx));
                end
                rx++;
                seen = 1'b1;
            end else if (seen) begin
                gaps++;
            end
            if (tx < 8) begin
                b_req_valid = 1'b1;
                b_req_write = 1'b0;
                b_req_addr  = AW'(tx);
                acc = (b_req_ready === 1'b1);
                if (!acc) stall++;
            end else begin
                b_req_valid = 1'b0;
                acc = 1'b0;
            end
            tick();
            if (acc) tx++;
        end
        b_req_valid = 1'b0;
        checks++;
        if (rx != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses, required 8", rx);
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL b2b_gaps: got %0d idle cycles, required 0", gaps);
        end
        checks++;
        if (stall != 0) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stalls, required 0", stall);
        end
        idle(4);
    endtask

    task automatic test_backpressure();
        int tx, rx;
        bit acc, unstable;
        logic [DW-1:0] snap;
        for (int i = 0; i < 3; i++) begin
            send(0, 1'b1, AW'(8'h30 + i), pat(8'h30 + i), '1);
        end
        idle(4);
        a_resp_ready = 1'b0;
        tx = 0;
        for (int c = 0; c < 6; c++) begin
            a_req_valid = 1'b1;
            a_req_write = 1'b0;
            a_req_addr  = AW'(8'h30 + tx);
            acc = (a_req_ready === 1'b1);
            tick();
            if (acc) tx++;
        end
        checks++;
        if (tx != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d, required 2", tx);
        end
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: got %b, required 0", a_req_ready);
        end
        snap = a_resp_rdata;
        checks++;
        if (snap !== pat(8'h30)) begin
            errors++;
            $display("FAIL bp_head: got %h, required %h", snap, pat(8'h30));
        end
        unstable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== snap) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_stable: head changed while stalled, required stable");
        end
        a_resp_ready = 1'b1;
        rx = 0;
        for (int c = 0; c < 20 && rx < 3; c++) begin
            if (a_resp_valid === 1'b1) begin
                checks++;
                if (a_resp_rdata !== pat(8'h30 + rx)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h, required %h",
                             rx, a_resp_rdata, pat(8'h30 + rx));
                end
                rx++;
            end
            if (tx < 3) begin
                a_req_valid = 1'b1;
                a_req_addr  = AW'(8'h30 + tx);
                acc = (a_req_ready === 1'b1);
            end else begin
                a_req_valid = 1'b0;
                acc = 1'b0;
            end
            tick();
            if (acc) tx++;
        end
        a_req_valid = 1'b0;
        checks++;
        if (tx != 3 || rx != 3) begin
            errors++;
            $display("FAIL bp_drain: got tx=%0d rx=%0d, required 3/3", tx, rx);
        end
        idle(3);
    endtask

    task automatic test_reset_midflight();
        bit ghost, found;
        logic [DW-1:0] d;
        send(0, 1'b1, 8'h20, pat(8'h20), '1);
        idle(3);
        a_resp_ready = 1'b0;
        send(0, 1'b0, 8'h30, '0, '0);
        send(0, 1'b0, 8'h31, '0, '0);
        rst = 1'b1;
        #1;
        checks++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: valid=%b ready=%b, required 0/0",
                     a_resp_valid, a_req_ready);
        end
        tick();
        rst = 1'b0;
        a_resp_ready = 1'b1;
        ghost = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_resp_valid !== 1'b0) ghost = 1'b1;
            tick();
        end
        checks++;
        if (ghost) begin
            errors++;
            $display("FAIL mid_dropped: stale response seen, required none");
        end
        send(0, 1'b0, 8'h20, '0, '0);
        get_read(0, d, found);
        checks++;
        if (!found || d !== pat(8'h20)) begin
            errors++;
            $display("FAIL mid_mem: found=%b data=%h, required 1/%h",
                     found, d, pat(8'h20));
        end
        idle(3);
    endtask

    task automatic test_write_resp();
        logic [DW-1:0] d;
        bit found;
`ifdef SIM_RAM_WRITE_RESP_EN
        send(0, 1'b1, 8'h40, pat(8'h40), '1);
        checks++;
        if (a_resp_valid !== 1'b1 || a_resp_is_wr !== 1'b1 ||
            a_resp_rdata !== '0) begin
            errors++;
            $display("FAIL wr_resp: v=%b wr=%b d=%h, required 1/1/0",
                     a_resp_valid, a_resp_is_wr, a_resp_rdata);
        end
        idle(2);
`else
        bit seen;
        seen = 1'b0;
        send(0, 1'b1, 8'h40, pat(8'h40), '1);
        for (int c = 0; c < 5; c++) begin
            if (a_resp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL wr_noresp: response seen, required none");
        end
        checks++;
        if (dut_a.out_q !== 2'd0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_credit: out=%0d ready=%b, required 0/1",
                     dut_a.out_q, a_req_ready);
        end
`endif
        send(0, 1'b0, 8'h40, '0, '0);
        get_read(0, d, found);
        checks++;
        if (!found || d !== pat(8'h40)) begin
            errors++;
            $display("FAIL wr_commit: found=%b data=%h, required 1/%h",
                     found, d, pat(8'h40));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
        a_req_wdata = '0;   a_req_wstrb = '0;   a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
        b_req_wdata = '0;   b_req_wstrb = '0;   b_resp_ready = 1'b1;
        #1;
        test_reset();
        test_strobe();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_write_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
